// File: rtl/cpu64_l2_victim_ctrl.sv
// rtl/cpu64_l2_victim_ctrl.sv - L2 miss/eviction sequencer driving a 16-way PLRU victim selector
// One miss in flight at a time; L2 hit recency updates share the PLRU port when the sequencer does not need it.
module cpu64_l2_victim_ctrl #(
  parameter int TAG_W = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             miss_valid_i,
  output logic             miss_ready_o,
  input  logic [7:0]       miss_set_i,
  input  logic [TAG_W-1:0] miss_tag_i,
  output logic             miss_done_o,
  output logic [3:0]       miss_way_o,
  output logic             miss_err_o,
  input  logic             hit_valid_i,
  output logic             hit_ready_o,
  input  logic [7:0]       hit_set_i,
  input  logic [3:0]       hit_way_i,
  output logic [7:0]       plru_set_o,
  output logic             plru_access_o,
  output logic [3:0]       plru_way_o,
  output logic [15:0]      plru_valid_o,
  input  logic [3:0]       plru_victim_i,
  output logic             meta_rd_o,
  output logic [7:0]       meta_set_o,
  input  logic [15:0]      meta_valid_i,
  input  logic [15:0]      meta_dirty_i,
  output logic             meta_wr_o,
  output logic [3:0]       meta_way_o,
  output logic [TAG_W-1:0] meta_tag_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [7:0]       wb_set_o,
  output logic [3:0]       wb_way_o,
  input  logic             wb_done_i,
  output logic             rf_valid_o,
  input  logic             rf_ready_i,
  output logic [7:0]       rf_set_o,
  output logic [3:0]       rf_way_o,
  output logic [TAG_W-1:0] rf_tag_o,
  input  logic             rf_done_i,
  input  logic             rf_err_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_SEL, S_WB_REQ, S_WB_WAIT, S_RF_REQ, S_RF_WAIT, S_INSTALL, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       set_q, set_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       victim_q, victim_d;
  logic             err_q, err_d;
  logic             hit_acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      set_q    <= '0;
      tag_q    <= '0;
      victim_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      err_q    <= err_d;
    end
  end

  // Only a dirty line that is actually valid needs a writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (miss_valid_i) state_d = S_RD;
      S_RD:      state_d = S_SEL;
      S_SEL:     state_d = (meta_valid_i[plru_victim_i] && meta_dirty_i[plru_victim_i])
                           ? S_WB_REQ : S_RF_REQ;
      S_WB_REQ:  if (wb_ready_i) state_d = S_WB_WAIT;
      S_WB_WAIT: if (wb_done_i) state_d = S_RF_REQ;
      S_RF_REQ:  if (rf_ready_i) state_d = S_RF_WAIT;
      S_RF_WAIT: if (rf_done_i) state_d = rf_err_i ? S_DONE : S_INSTALL;
      S_INSTALL: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    set_d    = set_q;
    tag_d    = tag_q;
    victim_d = victim_q;
    err_d    = err_q;
    if (state_q == S_IDLE && miss_valid_i) begin
      set_d = miss_set_i;
      tag_d = miss_tag_i;
      err_d = 1'b0;
    end
    if (state_q == S_SEL) victim_d = plru_victim_i;
    if (state_q == S_RF_WAIT && rf_done_i) err_d = rf_err_i;
  end

  // The sequencer owns the PLRU port in SEL (lookup) and INSTALL (update); hits get it otherwise.
  always_comb begin
    hit_ready_o   = !(state_q == S_SEL || state_q == S_INSTALL);
    hit_acc       = hit_valid_i && hit_ready_o;
    miss_ready_o  = rst_ni && (state_q == S_IDLE);
    miss_done_o   = (state_q == S_DONE);
    miss_way_o    = victim_q;
    miss_err_o    = err_q;
    meta_rd_o     = (state_q == S_RD);
    meta_set_o    = set_q;
    meta_wr_o     = (state_q == S_INSTALL);
    meta_way_o    = victim_q;
    meta_tag_o    = tag_q;
    wb_valid_o    = (state_q == S_WB_REQ);
    wb_set_o      = set_q;
    wb_way_o      = victim_q;
    rf_valid_o    = (state_q == S_RF_REQ);
    rf_set_o      = set_q;
    rf_way_o      = victim_q;
    rf_tag_o      = tag_q;
    plru_valid_o  = (state_q == S_SEL) ? meta_valid_i : 16'hFFFF;
    plru_access_o = (state_q == S_INSTALL) || hit_acc;
    plru_set_o    = hit_acc ? hit_set_i : set_q;
    plru_way_o    = hit_acc ? hit_way_i : victim_q;
  end

endmodule
